// File: rtl/debounce_sync_if.sv
// Bundles the debouncer's level input, qualification controls and committed outputs.
// The master side drives the raw level and controls; the slave side is the debouncer.
interface debounce_sync_if #(
    parameter int GLITCH_W = 8
);
    logic                data_in;
    logic                enable;
    logic                glitch_clr;
    logic                data_out;
    logic                rise_pulse;
    logic                fall_pulse;
    logic                busy;
    logic [GLITCH_W-1:0] glitch_count;

    modport master (
        output data_in, enable, glitch_clr,
        input  data_out, rise_pulse, fall_pulse, busy, glitch_count
    );

    modport slave (
        input  data_in, enable, glitch_clr,
        output data_out, rise_pulse, fall_pulse, busy, glitch_count
    );
endinterface

// File: rtl/debounce_sync.sv
// Synchronizes a raw asynchronous level, qualifies it over DEBOUNCE_CYCLES stable
// samples, and reports committed edges plus a saturating count of rejected candidates.
module debounce_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GLITCH_W        = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                data_in,
    input  logic                enable,
    input  logic                glitch_clr,
    output logic                data_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                busy,
    output logic [GLITCH_W-1:0] glitch_count,
    output logic [1:0]          state_dbg
);
    localparam logic [1:0] STABLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH   = 2'd1;
    localparam logic [1:0] STABLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW    = 2'd3;

    localparam logic [7:0]          DEB_CYCLES = 8'(DEBOUNCE_CYCLES);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
    localparam bit                  ONE_CYCLE  = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [7:0]             cnt;
    logic [7:0]             cnt_nxt;
    logic [8:0]             cnt_inc;
    logic                   commit_rise;
    logic                   commit_fall;
    logic                   glitch_hit;
    logic                   start_ok;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], data_in};
        end
    end

    assign sync_q  = sync_ff[SYNC_STAGES-1];
    assign cnt_inc = {1'b0, cnt} + 9'd1;

    // With single-cycle qualification a commit could follow the previous one on the
    // very next edge; holding off while a pulse is out keeps edge pulses apart.
    assign start_ok = enable && !(ONE_CYCLE && (rise_pulse || fall_pulse));

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        commit_rise = 1'b0;
        commit_fall = 1'b0;
        glitch_hit  = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (start_ok && sync_q) begin
                    if (ONE_CYCLE) begin
                        state_nxt   = STABLE_HIGH;
                        cnt_nxt     = 8'd0;
                        commit_rise = 1'b1;
                    end else begin
                        state_nxt = WAIT_HIGH;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (!enable) begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = 8'd0;
                end else if (sync_q) begin
                    if (cnt_inc == {1'b0, DEB_CYCLES}) begin
                        state_nxt   = STABLE_HIGH;
                        cnt_nxt     = 8'd0;
                        commit_rise = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc[7:0];
                    end
                end else begin
                    state_nxt  = STABLE_LOW;
                    cnt_nxt    = 8'd0;
                    glitch_hit = 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (start_ok && !sync_q) begin
                    if (ONE_CYCLE) begin
                        state_nxt   = STABLE_LOW;
                        cnt_nxt     = 8'd0;
                        commit_fall = 1'b1;
                    end else begin
                        state_nxt = WAIT_LOW;
                        cnt_nxt   = 8'd1;
                    end
                end
            end
            WAIT_LOW: begin
                if (!enable) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = 8'd0;
                end else if (!sync_q) begin
                    if (cnt_inc == {1'b0, DEB_CYCLES}) begin
                        state_nxt   = STABLE_LOW;
                        cnt_nxt     = 8'd0;
                        commit_fall = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc[7:0];
                    end
                end else begin
                    state_nxt  = STABLE_HIGH;
                    cnt_nxt    = 8'd0;
                    glitch_hit = 1'b1;
                end
            end
            default: begin
                state_nxt = STABLE_LOW;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= STABLE_LOW;
            cnt        <= 8'd0;
            data_out   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rise_pulse <= commit_rise;
            fall_pulse <= commit_fall;
            if (commit_rise) begin
                data_out <= 1'b1;
            end else if (commit_fall) begin
                data_out <= 1'b0;
            end
        end
    end

    // Clear takes priority over a glitch landing on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            glitch_count <= '0;
        end else if (glitch_clr) begin
            glitch_count <= '0;
        end else if (glitch_hit && (glitch_count != GLITCH_MAX)) begin
            glitch_count <= glitch_count + 1'b1;
        end
    end

    assign busy      = (state == WAIT_HIGH) || (state == WAIT_LOW);
    assign state_dbg = state;
endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: two instances (8-bit and 2-bit glitch counters) share one
// stimulus stream and are compared every cycle against a level/run-length model.
module tb_debounce_sync;
  localparam int S = 2;
  localparam int D = 4;

  logic clock;
  logic reset_n;

  debounce_sync_if #(.GLITCH_W(8)) bus ();
  debounce_sync_if #(.GLITCH_W(2)) bus_sat ();

  logic [1:0] state_dbg;
  logic [1:0] state_dbg_sat;

  debounce_sync #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .GLITCH_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .data_in(bus.data_in), .enable(bus.enable), .glitch_clr(bus.glitch_clr),
    .data_out(bus.data_out), .rise_pulse(bus.rise_pulse), .fall_pulse(bus.fall_pulse),
    .busy(bus.busy), .glitch_count(bus.glitch_count), .state_dbg(state_dbg)
  );

  debounce_sync #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .GLITCH_W(2)) dut_sat (
    .clock(clock), .reset_n(reset_n),
    .data_in(bus.data_in), .enable(bus.enable), .glitch_clr(bus.glitch_clr),
    .data_out(bus_sat.data_out), .rise_pulse(bus_sat.rise_pulse),
    .fall_pulse(bus_sat.fall_pulse), .busy(bus_sat.busy),
    .glitch_count(bus_sat.glitch_count), .state_dbg(state_dbg_sat)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard bookkeeping
  int n_tests = 0;
  int n_fail  = 0;
  int cnt_rise = 0;
  int cnt_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: committed level plus length of the current differing run
  logic sync_line[$];
  int   m_level, m_run, m_glitch;
  bit   m_rise, m_fall;

  task automatic model_reset();
    sync_line.delete();
    for (int i = 0; i < S; i++) sync_line.push_back(1'b0);
    m_level = 0; m_run = 0; m_glitch = 0; m_rise = 0; m_fall = 0;
  endtask

  task automatic model_step(input logic din, input logic en, input logic clr);
    int s;
    s = int'(sync_line.pop_front());
    sync_line.push_back(din);
    m_rise = 0;
    m_fall = 0;
    if (!en) begin
      m_run = 0;
    end else if (s != m_level) begin
      m_run++;
      if (m_run == D) begin
        m_level = s;
        m_rise  = (s == 1);
        m_fall  = (s == 0);
        m_run   = 0;
      end
    end else if (m_run != 0) begin
      m_run = 0;
      m_glitch++;
    end
    if (clr) m_glitch = 0;
  endtask

  function automatic logic [31:0] pack(input logic d, r, f, b, input logic [7:0] g);
    return {20'd0, d, r, f, b, g};
  endfunction

  initial model_reset();

  // one compare process, every cycle
  always @(posedge clock) begin
    logic [7:0] g8, g2;
    if (!reset_n) model_reset();
    else model_step(bus.data_in, bus.enable, bus.glitch_clr);
    #1;
    g8 = (m_glitch > 255) ? 8'd255 : 8'(m_glitch);
    g2 = (m_glitch > 3) ? 8'd3 : 8'(m_glitch);
    check("cycle_dut", pack(bus.data_out, bus.rise_pulse, bus.fall_pulse, bus.busy, bus.glitch_count),
          pack(1'(m_level), m_rise, m_fall, m_run != 0, g8));
    check("cycle_sat", pack(bus_sat.data_out, bus_sat.rise_pulse, bus_sat.fall_pulse, bus_sat.busy,
          {6'd0, bus_sat.glitch_count}), pack(1'(m_level), m_rise, m_fall, m_run != 0, g2));
    if (bus.rise_pulse) cnt_rise++;
    if (bus.fall_pulse) cnt_fall++;
  end

  // driver tasks
  task automatic do_reset(input logic din);
    @(negedge clock);
    reset_n = 1'b0;
    bus.data_in = din;
    bus.enable = 1'b1;
    bus.glitch_clr = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cnt_rise = 0;
    cnt_fall = 0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic measure_commit(input string name, input int exp_edges, input int exp_busy);
    int n = 0;
    int nb = 0;
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock);
      #2;
      n++;
      if (bus.data_out) begin
        seen = 1;
        check({name, "_pulse"}, {31'd0, bus.rise_pulse}, 32'd1);
      end else if (bus.busy) begin
        nb++;
      end
    end
    check({name, "_edges"}, n, exp_edges);
    check({name, "_busy"}, nb, exp_busy);
  endtask

  task automatic wait_busy(input string name);
    bit seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clock);
      #2;
      if (bus.busy) seen = 1;
    end
    check({name, "_busy_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic sync_glitch(input logic clr_on_glitch);
    @(negedge clock);
    bus.data_in = 1'b1;
    repeat (2) @(negedge clock);
    bus.data_in = 1'b0;
    repeat (2) @(negedge clock);
    bus.glitch_clr = clr_on_glitch;
    @(negedge clock);
    bus.glitch_clr = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int len;
    logic lvl;
    reset_n = 1'b0;
    bus.data_in = 1'b0;
    bus.enable = 1'b1;
    bus.glitch_clr = 1'b0;

    // reset state
    do_reset(1'b0);
    wait_edges(1);
    check("reset_outputs", pack(bus.data_out, bus.rise_pulse, bus.fall_pulse, bus.busy, bus.glitch_count), 32'd0);

    // clean step: commit on 6th edge, busy for 3 cycles before it
    @(negedge clock);
    bus.data_in = 1'b1;
    measure_commit("clean_step", 6, 3);
    wait_edges(2);
    check("clean_step_rise_count", cnt_rise, 1);
    @(negedge clock);
    bus.data_in = 1'b0;
    wait_edges(10);
    check("clean_step_fall_count", cnt_fall, 1);

    // single 20 ns glitch
    do_reset(1'b0);
    @(negedge clock);
    #2;
    bus.data_in = 1'b1;
    #20;
    bus.data_in = 1'b0;
    wait_edges(10);
    check("glitch_level", {31'd0, bus.data_out}, 32'd0);
    check("glitch_count", {24'd0, bus.glitch_count}, 32'd1);
    check("glitch_pulses", cnt_rise + cnt_fall, 0);

    // bounce train then hold, then release
    do_reset(1'b0);
    @(negedge clock);
    #2;
    repeat (5) begin
      bus.data_in = 1'b1;
      #15;
      bus.data_in = 1'b0;
      #10;
    end
    bus.data_in = 1'b1;
    wait_edges(12);
    check("bounce_rise_count", cnt_rise, 1);
    check("bounce_glitch_count", {24'd0, bus.glitch_count}, 32'd5);
    check("bounce_glitch_sat", {30'd0, bus_sat.glitch_count}, 32'd3);
    @(negedge clock);
    bus.data_in = 1'b0;
    wait_edges(12);
    check("bounce_fall_count", cnt_fall, 1);

    // enable abort during WAIT_HIGH, then resume
    do_reset(1'b0);
    @(negedge clock);
    bus.data_in = 1'b1;
    wait_busy("abort");
    @(negedge clock);
    bus.enable = 1'b0;
    wait_edges(1);
    check("abort_idle", pack(bus.data_out, bus.rise_pulse, bus.fall_pulse, bus.busy, bus.glitch_count), 32'd0);
    wait_edges(3);
    check("abort_hold", {31'd0, bus.busy}, 32'd0);
    @(negedge clock);
    bus.enable = 1'b1;
    begin
      int n = 0;
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clock);
        #2;
        n++;
        if (bus.rise_pulse) seen = 1;
      end
      check("abort_resume_edges", n, 4);
    end
    check("abort_glitch_count", {24'd0, bus.glitch_count}, 32'd0);

    // saturation and clear coincident with a glitch
    do_reset(1'b0);
    repeat (5) sync_glitch(1'b0);
    check("sat_count_w2", {30'd0, bus_sat.glitch_count}, 32'd3);
    check("sat_count_w8", {24'd0, bus.glitch_count}, 32'd5);
    sync_glitch(1'b1);
    check("clear_wins_w2", {30'd0, bus_sat.glitch_count}, 32'd0);
    check("clear_wins_w8", {24'd0, bus.glitch_count}, 32'd0);

    // async reset in the middle of WAIT_LOW
    do_reset(1'b0);
    @(negedge clock);
    bus.data_in = 1'b1;
    wait_edges(10);
    @(negedge clock);
    bus.data_in = 1'b0;
    wait_busy("midreset");
    @(negedge clock);
    #2;
    check("midreset_before", {30'd0, bus.data_out, bus.busy}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("midreset_dut", pack(bus.data_out, bus.rise_pulse, bus.fall_pulse, bus.busy, bus.glitch_count), 32'd0);
    check("midreset_sat", pack(bus_sat.data_out, bus_sat.rise_pulse, bus_sat.fall_pulse, bus_sat.busy,
          {6'd0, bus_sat.glitch_count}), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    wait_edges(10);
    check("midreset_no_fall", cnt_fall, 0);
    check("midreset_glitch", {24'd0, bus.glitch_count}, 32'd0);

    // leaving reset with data_in already high
    do_reset(1'b1);
    measure_commit("reset_high", 6, 3);

    // randomized runs
    do_reset(1'b0);
    for (int r = 0; r < 600; r++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        @(negedge clock);
        bus.data_in = lvl;
        bus.enable = ($urandom_range(0, 15) != 0);
        bus.glitch_clr = ($urandom_range(0, 40) == 0);
      end
    end
    @(negedge clock);
    bus.enable = 1'b1;
    bus.glitch_clr = 1'b0;
    wait_edges(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
